chunked_addsub: RTL and testbench
=================================

# chunked_addsub

Parametrised multi-cycle adder/subtractor that splits a WIDTH-bit operation into CHUNK-bit ripple slices, one slice per clock, LSB slice first. It trades latency for area. Full-adder slices are reused across cycles, and a carry register links consecutive slices. It sits in the datapath as a shared arithmetic unit behind a start/done handshake, and reports carry/borrow and signed overflow.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of CHUNK
- CHUNK, 4, bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH; N = WIDTH/CHUNK slices
- clk  in  1  rising-edge clock, the only clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- sub  in  1  0 = add, 1 = subtract; latched with start
- a  in  WIDTH  operand A; latched with start
- b  in  WIDTH  operand B; latched with start
- cin  in  1  carry-in (add) or borrow-in (sub); latched with start
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse; result valid
- s  out  WIDTH  result
- cout  out  1  carry-out (add) or borrow-out (sub)
- ovf  out  1  two's-complement signed overflow

## Operation
- States: IDLE, RUN, DONE.
- IDLE + start=1 at an edge: latch a, b' = sub ? ~b : b, carry = sub ? ~cin : cin; clear the slice index; go to RUN.
- RUN: each edge adds slice k of a, b' and carry. The sum slice goes into an internal result shift register, carry is updated, and k increments. After slice N-1, go to DONE.
- Add computes a + b + cin. Sub computes a − b − cin, implemented as a + ~b + ~cin.
- On the RUN→DONE edge, load s, cout and ovf:
  - cout = final carry when add, inverted final carry (borrow) when sub.
  - ovf = carry into MSB XOR carry out of MSB. Equivalently, operand signs of a and b' are equal and differ from the sign of s.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- s, cout and ovf change only on the RUN→DONE edge. They hold their value through the next operation until that operation's RUN→DONE edge. Partial sums are never visible on s.
- start is ignored in RUN and DONE. Operands changing during RUN have no effect.
- Reset (rst_n low, any time, including mid-RUN): state IDLE; busy, done, s, cout and ovf all 0; internal registers cleared. An aborted operation produces no done. Reset release takes effect at the first rising edge with rst_n high.

## Timing
- Start accepted at edge t.
- busy = 1 from after edge t through edge t+N.
- done = 1 between edges t+N and t+N+1, with the result valid in the same cycle.
- Latency from accept to done: N cycles.
- Earliest next accept is edge t+N+2 (the IDLE cycle). With start held high, one result is produced every N+2 cycles.
- N=1 (CHUNK=WIDTH): RUN lasts one cycle; done follows at t+1.
- All outputs are registered; none is combinational from inputs.
- The slice adder is combinational over CHUNK bits only. The critical path is a CHUNK-bit ripple.

## Test plan
All items use WIDTH=16, CHUNK=4 (N=4) unless noted.
- **Add:** a=0x1234, b=0x0FFF, cin=0, start at edge t.
  - s=0x2233, cout=0, ovf=0.
  - done high only after edge t+4; busy high after edges t..t+3.
- **Carry and overflow:**
  - 0xFFFF+0x0001, cin=0 → s=0x0000, cout=1, ovf=0.
  - 0x7FFF+0x0001 → s=0x8000, cout=0, ovf=1.
  - 0x0000+0x0000, cin=1 → s=0x0001.
- **Subtract:**
  - 0x0005−0x0007, cin=0 → s=0xFFFE, cout(borrow)=1, ovf=0.
  - 0x8000−0x0001 → s=0x7FFF, cout=0, ovf=1.
  - 0x0010−0x0001, cin=1 → s=0x000E.
- **Reset mid-RUN:** start, then drive rst_n low between edges t+2 and t+3.
  - All outputs 0 immediately.
  - No done pulse appears.
  - After release, a new 0x0001+0x0001 returns s=0x0002 with normal latency.
- **Handshake:**
  - start held high with operands changing every cycle → done every 6 cycles. Each result matches only the operands present at its accept edge.
  - A start pulse during RUN or DONE is ignored.
  - s is unchanged until the next done.
- **Parameter sweep:** CHUNK ∈ {1, 4, 16} with WIDTH=16, plus WIDTH=8/CHUNK=2.
  - 1000 random add/sub vectors checked against the arithmetic model for s, cout and ovf.
  - done latency equals WIDTH/CHUNK.

Source files
------------

// File: rtl/chunked_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per clock, LSB slice first; done follows accept by N=WIDTH/CHUNK cycles.
// No backpressure: start is sampled only in IDLE, so one result every N+2 cycles at most; all outputs registered.
module chunked_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("chunked_addsub: WIDTH must be a positive multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic             sub_q;
  logic [KW-1:0]    k_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             ovf_q;

  logic [CHUNK-1:0] sl_a;
  logic [CHUNK-1:0] sl_b;
  logic [CHUNK-1:0] sl_sum;
  logic             sl_c;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_d;
  logic [WIDTH-1:0] res_d;
  logic             last_slice;
  logic             ovf_d;

  // Operands shift right each cycle so the active slice always sits in the low CHUNK bits.
  assign sl_a = a_q[CHUNK-1:0];
  assign sl_b = b_q[CHUNK-1:0];
  assign {sl_c, sl_sum} = {1'b0, sl_a} + {1'b0, sl_b} + {{CHUNK{1'b0}}, carry_q};

  assign a_d   = a_q >> CHUNK;
  assign b_d   = b_q >> CHUNK;
  assign res_d = (res_q >> CHUNK) | (WIDTH'(sl_sum) << (WIDTH - CHUNK));

  assign last_slice = (k_q == KW'(N - 1));

  // In the top slice the operand sign bits are the MSBs of a and b'; overflow when they agree but the sum sign differs.
  assign ovf_d = (sl_a[CHUNK-1] == sl_b[CHUNK-1]) && (sl_sum[CHUNK-1] != sl_a[CHUNK-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ^ cin;
            sub_q   <= sub;
            k_q     <= '0;
            res_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_d;
          b_q     <= b_d;
          res_q   <= res_d;
          carry_q <= sl_c;
          k_q     <= k_q + KW'(1);
          if (last_slice) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            s_q     <= res_d;
            cout_q  <= sl_c ^ sub_q;
            ovf_q   <= ovf_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_chunked_addsub.sv
// Scoreboard bench for chunked_addsub over four WIDTH/CHUNK configurations driven in parallel.
module tb_chunked_addsub;

  typedef struct {
    logic [15:0] s;
    logic        cout;
    logic        ovf;
    longint      t;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int cfg, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cfg%0d: got %0h expected %0h at %0t", name, cfg, act, exp, $time);
    end
  endtask

  // Arithmetic reference: plain integer add/sub, signed range test for overflow.
  function automatic exp_t model(input int w, input bit sb, input int av, input int bv, input bit c);
    exp_t e;
    int m, half, full, sa, sbv, sres;
    m    = (1 << w) - 1;
    half = 1 << (w - 1);
    sa   = (av >= half) ? av - (1 << w) : av;
    sbv  = (bv >= half) ? bv - (1 << w) : bv;
    if (sb) begin
      full   = av - bv - int'(c);
      sres   = sa - sbv - int'(c);
      e.cout = (full < 0);
    end else begin
      full   = av + bv + int'(c);
      sres   = sa + sbv + int'(c);
      e.cout = (full > m);
    end
    e.s   = 16'(full & m);
    e.ovf = (sres >= half) || (sres < -half);
    e.t   = 0;
    return e;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : cfg
    localparam int W = (g == 3) ? 8 : 16;
    localparam int C = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 16 : 2;
    localparam int N = W / C;
    localparam int M = (1 << W) - 1;

    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub   = 1'b0;
    logic         cin   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy, done, cout, ovf;
    logic [W-1:0] s;

    exp_t   q[$];
    exp_t   last;
    longint cyc     = 0;
    longint next_ok = 0;
    int     n_acc   = 0;
    bit     mon_en  = 1'b0;
    bit     fin_b   = 1'b0;
    bit     m_eb, m_ed;
    longint m_d;

    chunked_addsub #(.WIDTH(W), .CHUNK(C)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start),
      .sub  (sub),
      .a    (a),
      .b    (b),
      .cin  (cin),
      .busy (busy),
      .done (done),
      .s    (s),
      .cout (cout),
      .ovf  (ovf)
    );

    // Acceptance follows the handshake rule: an edge with start high accepts if the unit has been free since t+N+2.
    always @(posedge clk) begin
      exp_t e;
      cyc++;
      if (rst_n && start && cyc >= next_ok) begin
        e   = model(W, sub, int'(a), int'(b), cin);
        e.t = cyc;
        q.push_back(e);
        next_ok = cyc + N + 2;
        n_acc++;
      end
    end

    always @(negedge clk) begin
      if (mon_en) begin
        m_eb = 1'b0;
        m_ed = 1'b0;
        if (q.size() != 0) begin
          m_d  = cyc - q[0].t;
          m_eb = (m_d < N);
          m_ed = (m_d == N);
        end
        check("busy", g, 32'(busy), 32'(m_eb));
        check("done", g, 32'(done), 32'(m_ed));
        if (m_ed) last = q.pop_front();
        check("s", g, 32'(s), 32'(last.s));
        check("cout", g, 32'(cout), 32'(last.cout));
        check("ovf", g, 32'(ovf), 32'(last.ovf));
      end
    end

    task automatic model_reset();
      q.delete();
      last.s    = '0;
      last.cout = 1'b0;
      last.ovf  = 1'b0;
      last.t    = 0;
      next_ok   = 0;
    endtask

    task automatic issue(input bit sb, input int av, input int bv, input bit c);
      int acc0;
      acc0  = n_acc;
      sub   = sb;
      a     = W'(av);
      b     = W'(bv);
      cin   = c;
      start = 1'b1;
      for (int i = 0; i < N + 4 && n_acc == acc0; i++) begin
        @(posedge clk);
        #1;
      end
      start = 1'b0;
      check("accept", g, 32'(n_acc - acc0), 32'd1);
    endtask

    task automatic drain();
      for (int i = 0; i < N + 4 && q.size() != 0; i++) @(negedge clk);
      check("drain", g, 32'(q.size()), 32'd0);
      @(posedge clk);
      #1;
    endtask

    function automatic int rnd_op();
      case ($urandom_range(0, 7))
        0:       return 0;
        1:       return M;
        2:       return M >> 1;
        3:       return (M >> 1) + 1;
        4:       return 1;
        default: return int'($urandom) & M;
      endcase
    endfunction

    initial begin
      int acc0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 mon_en = 1'b1;
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Directed vectors {sub, a, b, cin}, truncated to W bits.
      issue(0, 'h1234 & M, 'h0FFF & M, 0); drain();
      issue(0, 'hFFFF & M, 'h0001,     0); drain();
      issue(0, 'h7FFF & M, 'h0001,     0); drain();
      issue(0, 'h0000,     'h0000,     1); drain();
      issue(1, 'h0005,     'h0007,     0); drain();
      issue(1, 'h8000 & M, 'h0001,     0); drain();
      issue(1, 'h0010,     'h0001,     1); drain();

      // Start pulses while in RUN and DONE must be ignored.
      issue(0, 'h00AB, 'h0011, 0);
      sub = 1'b1; a = W'(M); b = W'(3); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (N - 1) @(posedge clk);
      #1 a = W'(5); b = W'(9); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      drain();

      // Reset between edges t+2 and t+3 aborts the operation without a done.
      issue(0, 'h1234 & M, 'h0FFF & M, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("rst_busy", g, 32'(busy), 32'd0);
      check("rst_done", g, 32'(done), 32'd0);
      check("rst_s", g, 32'(s), 32'd0);
      check("rst_cout", g, 32'(cout), 32'd0);
      check("rst_ovf", g, 32'(ovf), 32'd0);
      repeat (N + 3) @(posedge clk);
      #1 rst_n = 1'b1;
      issue(0, 1, 1, 0); drain();

      // Start held high, operands changing every cycle.
      acc0  = n_acc;
      start = 1'b1;
      for (int i = 0; i < 500 * (N + 2) + 20 && n_acc - acc0 < 500; i++) begin
        sub = 1'($urandom); cin = 1'($urandom);
        a = W'(rnd_op()); b = W'(rnd_op());
        @(posedge clk); #1;
      end
      start = 1'b0;
      check("held_count", g, 32'(n_acc - acc0), 32'd500);
      drain();

      // Random start pulses with random operands.
      acc0 = n_acc;
      for (int i = 0; i < 500 * (N + 2) * 4 && n_acc - acc0 < 500; i++) begin
        start = ($urandom_range(0, 2) == 0);
        sub = 1'($urandom); cin = 1'($urandom);
        a = W'(rnd_op()); b = W'(rnd_op());
        @(posedge clk); #1;
      end
      start = 1'b0;
      check("pulse_count", g, 32'(n_acc - acc0), 32'd500);
      drain();
      fin_b = 1'b1;
    end
  end

  initial begin
    int nfin;
    nfin = 0;
    for (int i = 0; i < 80000 && nfin != 4; i++) begin
      @(posedge clk);
      nfin = int'(cfg[0].fin_b) + int'(cfg[1].fin_b) + int'(cfg[2].fin_b) + int'(cfg[3].fin_b);
    end
    check("all_finished", -1, 32'(nfin), 32'd4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
